// File: rtl/zxw_cpu_ctrl.sv
// Multi-cycle control unit for the lab 9 accumulator datapath.
// Owns PC and IR, sequences fetch/decode/execute and drives the datapath strobes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FETCH  | present PC to RAM; wait for run=1
// S_LATCH  | capture instruction into IR, advance PC
// S_DECODE | present operand address; one-cycle ops finish here
// S_READ   | operand data valid; load accumulator through the ALU
// S_HALT   | stopped until reset
module zxw_cpu_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              run,
  input  logic              zero,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              acc_load,
  output logic [1:0]        alu_op,
  output logic              disp_load,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_LATCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_JMP   = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_OUT   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand;

  assign opcode  = ir_q[DATA_W-1 -: 3];
  assign operand = ir_q[ADDR_W-1:0];

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs depend only on state and IR so reset forces every strobe low.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mem_addr  = '0;
    mem_we    = 1'b0;
    acc_load  = 1'b0;
    alu_op    = 2'b00;
    disp_load = 1'b0;
    halted    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_addr = pc_q;
        if (run) state_d = S_LATCH;
      end
      S_LATCH: begin
        mem_addr = pc_q;
        ir_d     = mem_rdata;
        pc_d     = pc_q + ADDR_W'(1);
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        mem_addr = operand;
        state_d  = S_FETCH;
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUB: state_d = S_READ;
          OP_STORE: mem_we = 1'b1;
          OP_JMP:   pc_d = operand;
          OP_JZ:    if (zero) pc_d = operand;
          OP_OUT:   disp_load = 1'b1;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_FETCH;
        endcase
      end
      S_READ: begin
        mem_addr = operand;
        acc_load = 1'b1;
        state_d  = S_FETCH;
        case (opcode)
          OP_ADD:  alu_op = 2'b01;
          OP_SUB:  alu_op = 2'b10;
          default: alu_op = 2'b00;
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign pc    = pc_q;
  assign state = state_q;

endmodule

// File: tb/tb_zxw_cpu_ctrl.sv
// Bench for zxw_cpu_ctrl: RAM/accumulator environment plus an instruction-level
// reference interpreter; directed scenarios followed by random programs.
module tb_zxw_cpu_ctrl;

  logic       Clock = 1'b0;
  logic       Resetn, run, zero;
  logic [7:0] mem_rdata;
  logic [4:0] mem_addr;
  logic       mem_we, acc_load, disp_load, halted;
  logic [1:0] alu_op;
  logic [4:0] pc;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  logic [7:0] img [32];
  logic [7:0] acc_init;
  logic       load_img;
  logic [7:0] ram [32];
  logic [7:0] acc, disp;

  // instruction-level model state
  logic [7:0] mm [32];
  logic [4:0] mpc;
  logic [7:0] macc, mdisp;
  bit         mhalt;

  always #5 Clock = ~Clock;

  zxw_cpu_ctrl dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .run       (run),
    .zero      (zero),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .acc_load  (acc_load),
    .alu_op    (alu_op),
    .disp_load (disp_load),
    .halted    (halted),
    .pc        (pc),
    .state     (state)
  );

  assign zero = (acc == 8'd0);

  // datapath stand-in: synchronous-read RAM, accumulator, display register
  always @(posedge Clock) begin
    mem_rdata <= ram[mem_addr];
    if (load_img) begin
      ram  <= img;
      acc  <= acc_init;
      disp <= 8'd0;
    end else begin
      if (mem_we) ram[mem_addr] <= acc;
      if (acc_load) begin
        case (alu_op)
          2'b00:   acc <= mem_rdata;
          2'b01:   acc <= acc + mem_rdata;
          2'b10:   acc <= acc - mem_rdata;
          default: acc <= acc;
        endcase
      end
      if (disp_load) disp <= acc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = 8'd0;
    acc_init = 8'd0;
  endtask

  task automatic reset_load(input int n);
    Resetn   = 1'b0;
    run      = 1'b0;
    load_img = 1'b1;
    repeat (n) tick();
    load_img = 1'b0;
    Resetn   = 1'b1;
    for (int i = 0; i < 32; i++) mm[i] = img[i];
    mpc   = 5'd0;
    macc  = acc_init;
    mdisp = 8'd0;
    mhalt = 1'b0;
  endtask

  // Execute one instruction from S_FETCH; compare against the interpreter.
  task automatic exec_one(input bit rand_run);
    logic [2:0] op;
    logic [4:0] a, npc, waddr;
    logic [7:0] nacc;
    logic [1:0] aop, exp_aop;
    int ec, n_al, n_we, n_dl, multi;
    bit is_rd;
    op      = mm[mpc][7:5];
    a       = mm[mpc][4:0];
    is_rd   = (op == 3'd0) || (op == 3'd2) || (op == 3'd3);
    ec      = is_rd ? 4 : 3;
    exp_aop = (op == 3'd2) ? 2'b01 : (op == 3'd3) ? 2'b10 : 2'b00;
    npc     = mpc + 5'd1;
    nacc    = macc;
    case (op)
      3'd0: nacc = mm[a];
      3'd1: mm[a] = macc;
      3'd2: nacc = macc + mm[a];
      3'd3: nacc = macc - mm[a];
      3'd4: npc = a;
      3'd5: if (macc == 8'd0) npc = a;
      3'd6: mdisp = macc;
      default: mhalt = 1'b1;
    endcase
    run = 1'b1;
    n_al = 0; n_we = 0; n_dl = 0; multi = 0; aop = 2'b11; waddr = 5'd0;
    for (int c = 0; c < ec; c++) begin
      if (acc_load) begin n_al++; aop = alu_op; end
      if (mem_we) begin n_we++; waddr = mem_addr; end
      if (disp_load) n_dl++;
      if (int'(acc_load) + int'(mem_we) + int'(disp_load) > 1) multi++;
      tick();
      if (rand_run && c == 0) run = 1'($urandom_range(0, 1));
    end
    mpc  = npc;
    macc = nacc;
    chk("state_after", state, mhalt ? 4 : 0);
    chk("pc_after", pc, mpc);
    chk("acc_after", acc, macc);
    chk("disp_after", disp, mdisp);
    chk("halted_after", halted, mhalt);
    chk("acc_load_pulses", n_al, is_rd ? 1 : 0);
    chk("mem_we_pulses", n_we, (op == 3'd1) ? 1 : 0);
    chk("disp_load_pulses", n_dl, (op == 3'd6) ? 1 : 0);
    chk("strobe_overlap", multi, 0);
    if (is_rd) chk("alu_op", aop, exp_aop);
    if (op == 3'd1) begin
      chk("store_addr", waddr, a);
      chk("store_data", ram[a], mm[a]);
    end
  endtask

  initial begin
    int cnt, n_al, n_dl;
    logic [1:0] ops [2];
    Resetn = 1'b0; run = 1'b0; load_img = 1'b1;
    clear_img();

    // reset and hold
    repeat (10) tick();
    chk("rst_state", state, 0);
    chk("rst_pc", pc, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_acc_load", acc_load, 0);
    chk("rst_disp_load", disp_load, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_halted", halted, 0);
    load_img = 1'b0; Resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_state", state, 0);
      chk("hold_pc", pc, 0);
    end

    // straight line: LOAD 30, ADD 31, OUT, HALT
    clear_img();
    img[0] = 8'h1E; img[1] = 8'h5F; img[2] = 8'hC0; img[3] = 8'hE0;
    img[30] = 8'd3; img[31] = 8'd4;
    reset_load(2);
    run = 1'b1; cnt = 0; n_al = 0; n_dl = 0; ops[0] = 2'b11; ops[1] = 2'b11;
    while (!halted && cnt < 40) begin
      if (acc_load) begin
        if (n_al < 2) ops[n_al] = alu_op;
        n_al++;
      end
      if (disp_load) n_dl++;
      tick();
      cnt++;
    end
    chk("sl_halt_cycle", cnt, 14);
    chk("sl_acc_loads", n_al, 2);
    chk("sl_alu_op0", ops[0], 2'b00);
    chk("sl_alu_op1", ops[1], 2'b01);
    chk("sl_disp_loads", n_dl, 1);
    chk("sl_disp", disp, 8'd7);
    chk("sl_pc", pc, 4);

    // store strobe timing
    clear_img();
    img[0] = 8'h3D; acc_init = 8'h5A;
    reset_load(2);
    run = 1'b1;
    tick(); tick();
    chk("st_we", mem_we, 1);
    chk("st_addr", mem_addr, 29);
    tick();
    chk("st_we_off", mem_we, 0);
    chk("st_ram", ram[29], 8'h5A);

    // branches
    clear_img();
    img[0] = 8'hAA;
    reset_load(2);
    exec_one(1'b0);
    chk("jz_taken_pc", pc, 10);
    acc_init = 8'd5;
    reset_load(2);
    exec_one(1'b0);
    chk("jz_not_taken_pc", pc, 1);
    clear_img();
    img[0] = 8'h9F; img[31] = 8'h1E; img[30] = 8'd9;
    reset_load(2);
    exec_one(1'b0);
    chk("jmp_pc", pc, 31);
    exec_one(1'b0);
    chk("wrap_pc", pc, 0);

    // reset mid-instruction and during halt
    clear_img();
    img[0] = 8'h1E;
    reset_load(2);
    run = 1'b1;
    repeat (3) tick();
    chk("mid_in_read", state, 3);
    Resetn = 1'b0;
    tick();
    chk("mid_rst_state", state, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_acc_load", acc_load, 0);
    Resetn = 1'b1;
    clear_img();
    img[0] = 8'hE0;
    reset_load(2);
    run = 1'b1;
    repeat (3) tick();
    chk("halt_reached", halted, 1);
    repeat (3) tick();
    chk("halt_sticky", state, 4);
    Resetn = 1'b0;
    tick();
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_state", state, 0);
    Resetn = 1'b1;

    // pause during ADD
    clear_img();
    img[0] = 8'h5F; img[31] = 8'd4; acc_init = 8'd1;
    reset_load(2);
    run = 1'b1;
    tick(); tick();
    chk("pause_decode", state, 2);
    run = 1'b0;
    tick();
    chk("pause_read", state, 3);
    chk("pause_acc_load", acc_load, 1);
    chk("pause_alu_op", alu_op, 2'b01);
    tick();
    chk("pause_fetch", state, 0);
    chk("pause_acc", acc, 8'd5);
    repeat (6) tick();
    chk("pause_hold_state", state, 0);
    chk("pause_hold_pc", pc, 1);
    run = 1'b1;
    tick();
    chk("pause_resume", state, 1);

    // random programs against the interpreter
    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
      acc_init = 8'($urandom_range(0, 2));
      reset_load(2);
      for (int k = 0; k < 40 && !mhalt; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          run = 1'b0;
          repeat ($urandom_range(1, 5)) tick();
          chk("rnd_pause_state", state, 0);
          chk("rnd_pause_pc", pc, mpc);
        end
        exec_one(1'b1);
      end
      if (mhalt) begin
        repeat (3) tick();
        chk("rnd_halt_hold", state, 4);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zxw_cpu_ctrl.md
Name: zxw_cpu_ctrl

Overview:
- Multi-cycle control unit for the lab 9 accumulator datapath: register file/accumulator, ALU, 32x8 synchronous-read RAM, display register.
- Owns PC and IR; sequences fetch/decode/execute; drives RAM address, write strobe, accumulator load, ALU select and display load.
- Instantiated inside the lab top level alongside the datapath; display of `pc`/`state` is optional debug.

Parameters:
- ADDR_W, 5, RAM address width; also operand field width.
- DATA_W, 8, instruction/data width; must equal 3+ADDR_W.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  synchronous active-low reset.
- run  in  1  1 = execute; 0 = hold in S_FETCH. Top level ties this to SW_in[4].
- zero  in  1  accumulator==0 flag from datapath.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_addr is presented.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write strobe; RAM writes the accumulator.
- acc_load  out  1  accumulator load enable.
- alu_op  out  2  00 pass mem_rdata, 01 ACC+mem_rdata, 10 ACC-mem_rdata, 11 unused.
- disp_load  out  1  load display register from ACC.
- halted  out  1  high in S_HALT.
- pc  out  ADDR_W  current PC, debug.
- state  out  3  state encoding, debug.

Behaviour:
- Clock and reset:
  - Single clock domain; Resetn is synchronous and active-low.
  - Reset takes priority over every transition, including mid-instruction and during S_HALT.
  - On reset: state=S_FETCH, PC=0, IR=0.
- Output timing:
  - Outputs are combinational from state and IR, so in reset: mem_addr=0, mem_we=0, acc_load=0, disp_load=0, alu_op=00, halted=0.
- Instruction format: IR[7:5]=opcode, IR[4:0]=operand address A.
- Opcodes:
  - 000 LOAD: ACC=M[A].
  - 001 STORE: M[A]=ACC.
  - 010 ADD.
  - 011 SUB.
  - 100 JMP.
  - 101 JZ.
  - 110 OUT.
  - 111 HALT.
- States, encoded 0..4:
  - S_FETCH (0): mem_addr=PC. If run=1, go to S_LATCH; else stay.
  - S_LATCH (1): mem_addr=PC. IR<=mem_rdata. PC<=PC+1, wrapping 31->0. Go to S_DECODE.
  - S_DECODE (2): mem_addr=A. Action and next state by opcode:
    - LOAD/ADD/SUB: go to S_READ.
    - STORE: mem_we=1 for exactly this cycle, then S_FETCH.
    - JMP: PC<=A, then S_FETCH.
    - JZ: if zero=1, PC<=A; else PC unchanged. Then S_FETCH.
    - OUT: disp_load=1 for exactly this cycle, then S_FETCH.
    - HALT: go to S_HALT.
  - S_READ (3): mem_addr=A, mem_rdata valid. acc_load=1. alu_op=00/01/10 for LOAD/ADD/SUB. Go to S_FETCH.
  - S_HALT (4): halted=1, all strobes 0. Exit only by reset.
  - Illegal state encodings (5-7) go to S_FETCH on the next clock.
- Cycle counts:
  - LOAD/ADD/SUB: 4 cycles.
  - All other opcodes: 3 cycles.
  - Reaching S_HALT takes 3 cycles.
- Strobes:
  - At most one of mem_we, acc_load, disp_load is high in any cycle.
  - None is high outside S_DECODE or S_READ.
- JZ samples `zero` in S_DECODE only.
- run=0 only takes effect in S_FETCH; an instruction already in progress completes.
- Jump to the current PC (JMP to own address) is legal and loops forever.

Test Plan:
- Reset and hold:
  - Stimulus: Resetn=0 for 10 cycles.
  - Required: state=0, pc=0, all strobes 0, halted=0.
  - Stimulus: Resetn=1, run=0 for 20 cycles.
  - Required: state stays 0, pc stays 0.
- Straight line:
  - Program: M[0]=0x1E (LOAD 30), M[1]=0x5F (ADD 31), M[2]=0xC0 (OUT), M[3]=0xE0 (HALT); data M[30]=3, M[31]=4.
  - Required: acc_load pulses twice with alu_op 00 then 01; disp_load pulses once; halted rises on cycle 14 after run=1; pc=4.
- Store:
  - Program: M[0]=0x3D (STORE 29).
  - Required: in cycle 3, mem_we=1 and mem_addr=29 for exactly one cycle.
- Branch:
  - JZ 10 (0xAA) with zero=1: pc=10 in the following S_FETCH.
  - Same with zero=0: pc=1.
  - JMP 31 (0x9F): pc=31. Then the next fetch of NOP-like LOAD at 31: PC wraps to 0.
- Reset mid-instruction:
  - Stimulus: assert Resetn=0 while in S_READ.
  - Required: next cycle state=0, pc=0, acc_load=0.
  - Stimulus: assert Resetn=0 while in S_HALT.
  - Required: halted=0 next cycle.
- Pause:
  - Stimulus: run=0 asserted during S_DECODE of ADD.
  - Required: S_READ completes with acc_load=1, then the FSM holds in S_FETCH with pc unchanged until run=1.
